ex_stage: RTL and testbench

Execute stage of the five-stage datapath. Sits directly upstream of the memory-access stage and produces its ALU result, zero flag, store data and jump target. Integer ALU ops complete in one cycle. RV32M multiply/divide ops run on an iterative sub-unit and stall the pipeline until done.

---
 rtl/ex_stage_pkg.sv | 57 +++++
 rtl/ex_stage_muldiv.sv | 162 ++++++++++++++++
 rtl/ex_stage.sv | 142 ++++++++++++++
 tb/tb_ex_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage: ALU op codes,
// RV32 major opcodes, and the mul/div sub-unit op and state encodings.
`ifndef XLEN
`define XLEN 32
`endif

package ex_stage_pkg;

    localparam int XLEN = `XLEN;

    // RV32 major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct7 value that selects the RV32M group under OPC_OP
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    // Encoded so that the value equals funct3 of the M instruction
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring
// divider sharing one IDLE/BUSY/DONE sequencer. Operands are reduced to
// magnitudes on entry and the sign of the result is fixed on the way out.
//
// Handshake: while start is high in IDLE (and flush is low) busy rises
// combinationally; operands are captured at the next edge. busy stays high
// for the whole BUSY phase. In DONE busy is low, done is high and result is
// valid; the unit leaves DONE at the first edge where hold is low. flush
// returns the unit to IDLE at the next edge from BUSY or DONE and beats a
// simultaneous start in IDLE. rst forces busy low immediately.
module ex_stage_muldiv
    import ex_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic         hold,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [1:0]   state
);

    localparam int CW = $clog2(W);

    md_state_e      state_q;
    md_op_e         op_q;
    md_op_e         op_in;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] prod_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   a_orig_q;
    logic           b_zero_q;
    logic           res_neg_q;
    logic           rem_neg_q;

    logic           a_signed;
    logic           b_signed;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_try;
    logic [W:0]     div_diff;
    logic           div_ge;
    logic [W-1:0]   rem_next;
    logic [W-1:0]   quo_next;

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic           unused_bits;

    assign op_in = md_op_e'(op);

    // Operand signedness and magnitudes for the incoming op
    always_comb begin
        a_signed = (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                   (op_in == MD_DIV)  || (op_in == MD_REM);
        b_signed = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
        a_neg    = a_signed & a[W-1];
        b_neg    = b_signed & b[W-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    // One multiply step and one restoring-divide step per cycle
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, prod_q[W-1:1]};
        div_try  = {rem_q, quo_q[W-1]};
        div_diff = div_try - {1'b0, b_q};
        div_ge   = (div_try >= {1'b0, b_q});
        rem_next = div_ge ? div_diff[W-1:0] : div_try[W-1:0];
        quo_next = {quo_q[W-2:0], div_ge};
    end

    assign unused_bits = div_diff[W];

    // Sequencer and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_MUL;
            cnt_q     <= '0;
            prod_q    <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            a_orig_q  <= '0;
            b_zero_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start && !flush) begin
                        state_q   <= MD_BUSY;
                        op_q      <= op_in;
                        cnt_q     <= '0;
                        prod_q    <= {{W{1'b0}}, a_mag};
                        b_q       <= b_mag;
                        quo_q     <= a_mag;
                        rem_q     <= '0;
                        a_orig_q  <= a;
                        b_zero_q  <= (b == '0);
                        res_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                    end
                end
                MD_BUSY: begin
                    if (flush) begin
                        state_q <= MD_IDLE;
                    end else begin
                        prod_q <= mul_next;
                        rem_q  <= rem_next;
                        quo_q  <= quo_next;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(W-1)) begin
                            state_q <= MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    if (flush || !hold) begin
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    // Sign correction and result select; divide by zero bypasses the signs
    always_comb begin
        prod_fix = res_neg_q ? -prod_q : prod_q;
        quo_fix  = res_neg_q ? -quo_q  : quo_q;
        rem_fix  = rem_neg_q ? -rem_q  : rem_q;
        case (op_q)
            MD_MUL:                        result = prod_fix[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_fix[2*W-1:W];
            MD_DIV, MD_DIVU:               result = b_zero_q ? {W{1'b1}} : quo_fix;
            default:                       result = b_zero_q ? a_orig_q : rem_fix;
        endcase
    end

    assign busy  = !rst && (((state_q == MD_IDLE) && start && !flush) || (state_q == MD_BUSY));
    assign done  = (state_q == MD_DONE);
    assign state = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle integer ALU with opcode decode and operand
// muxing, plus an iterative RV32M unit that stalls upstream while it works.
// o_stall high means the ID/EX contents must not advance; when it is low the
// outputs describe the instruction currently held in ID/EX.
`ifndef XLEN
`define XLEN 32
`endif

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter bit MULDIV_EN = 1'b1,
    parameter int XLEN_P    = `XLEN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [31:0]       i_inst,
    input  logic [XLEN_P-1:0] i_pc,
    input  logic [XLEN_P-1:0] i_rs1,
    input  logic [XLEN_P-1:0] i_rs2,
    input  logic [XLEN_P-1:0] i_imm,
    input  logic              i_alu_src,
    input  logic              i_flush,
    input  logic              i_hold,
    output logic [XLEN_P-1:0] o_alu_res,
    output logic              o_z,
    output logic [XLEN_P-1:0] o_wr_data,
    output logic [XLEN_P-1:0] o_pc_jump,
    output logic              o_stall
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic              is_mop;
    alu_op_e           alu_op;
    logic [XLEN_P-1:0] op_a;
    logic [XLEN_P-1:0] op_b;
    logic [XLEN_P-1:0] alu_res;

    logic              md_busy;
    logic              md_done;
    logic [XLEN_P-1:0] md_result;
    logic [1:0]        md_state;
    logic              unused_inst;

    assign opcode = i_inst[6:0];
    assign f3     = i_inst[14:12];
    assign f7     = i_inst[31:25];
    assign is_mop = (opcode == OPC_OP) && (f7 == F7_MULDIV);

    assign unused_inst = ^{i_inst[24:15], i_inst[11:7]};

    // Decode the ALU operation and choose operands
    always_comb begin
        alu_op = ALU_ADD;
        op_a   = i_rs1;
        op_b   = i_alu_src ? i_imm : i_rs2;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                // M-group encodings fall through as ADD
                if (!is_mop) begin
                    case (f3)
                        3'b000:  alu_op = ((opcode == OPC_OP) && f7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_op = ALU_SLL;
                        3'b010:  alu_op = ALU_SLT;
                        3'b011:  alu_op = ALU_SLTU;
                        3'b100:  alu_op = ALU_XOR;
                        3'b101:  alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end
            end
            OPC_LUI:   alu_op = ALU_PASS_B;
            OPC_AUIPC: op_a   = i_pc;
            OPC_BRANCH: begin
                op_b = i_rs2;
                case (f3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: op_b = i_imm;
            default: alu_op = ALU_ADD;
        endcase
    end

    // Single-cycle integer ALU
    always_comb begin
        case (alu_op)
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << op_b[4:0];
            ALU_SRL:    alu_res = op_a >> op_b[4:0];
            ALU_SRA:    alu_res = $signed(op_a) >>> op_b[4:0];
            ALU_SLT:    alu_res = {{(XLEN_P-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:   alu_res = {{(XLEN_P-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = op_a + op_b;
        endcase
    end

    generate
        if (MULDIV_EN) begin : g_muldiv
            ex_stage_muldiv #(
                .W(XLEN_P)
            ) u_muldiv (
                .clk    (i_clk),
                .rst    (i_rst),
                .start  (i_valid && is_mop),
                .flush  (i_flush),
                .hold   (i_hold),
                .op     (f3),
                .a      (i_rs1),
                .b      (i_rs2),
                .busy   (md_busy),
                .done   (md_done),
                .result (md_result),
                .state  (md_state)
            );
        end else begin : g_no_muldiv
            logic unused_md;
            assign unused_md = ^{i_clk, i_rst, i_valid, i_flush, i_hold};
            assign md_busy   = 1'b0;
            assign md_done   = 1'b0;
            assign md_result = '0;
            assign md_state  = MD_IDLE;
        end
    endgenerate

    assign o_alu_res = md_done ? md_result : alu_res;
    assign o_z       = (o_alu_res == '0);
    assign o_wr_data = i_rs2;
    assign o_pc_jump = i_pc + i_imm;
    assign o_stall   = md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: drivers push expected results into a
// scoreboard queue and a negedge monitor pops one whenever the stage
// presents a live, unstalled, unflushed result.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        alu_src;
    logic        flush;
    logic        hold;
    logic [31:0] alu_res;
    logic        z;
    logic [31:0] wr_data;
    logic [31:0] pc_jump;
    logic        stall;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    localparam logic [31:0] I_ADDI  = 32'h0000_0013;
    localparam logic [31:0] I_SUB   = 32'h4000_0033;
    localparam logic [31:0] I_ADD   = 32'h0000_0033;
    localparam logic [31:0] I_SRA   = 32'h4000_5033;
    localparam logic [31:0] I_SLL   = 32'h0000_1033;
    localparam logic [31:0] I_SLT   = 32'h0000_2033;
    localparam logic [31:0] I_SLTU  = 32'h0000_3033;
    localparam logic [31:0] I_LUI   = 32'h0000_0037;
    localparam logic [31:0] I_AUIPC = 32'h0000_0017;
    localparam logic [31:0] I_BLT   = 32'h0000_4063;
    localparam logic [31:0] I_LW    = 32'h0000_2003;
    localparam logic [31:0] I_MOP   = 32'h0200_0033;

    ex_stage dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_inst    (inst),
        .i_pc      (pc),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_imm     (imm),
        .i_alu_src (alu_src),
        .i_flush   (flush),
        .i_hold    (hold),
        .o_alu_res (alu_res),
        .o_z       (z),
        .o_wr_data (wr_data),
        .o_pc_jump (pc_jump),
        .o_stall   (stall)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && valid && !stall && !flush) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_output", alu_res, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, alu_res, e);
                chk({nm, "_z"}, {31'd0, z}, {31'd0, (e == 32'd0)});
            end
        end
    end

    // driver tasks
    task automatic push(input string nm, input logic [31:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drive(input logic [31:0] in_inst, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [31:0] p);
        valid   = 1'b1;
        inst    = in_inst;
        rs1     = a;
        rs2     = b;
        imm     = im;
        alu_src = src;
        pc      = p;
    endtask

    task automatic alu_op(input string nm, input logic [31:0] in_inst, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im, input logic src,
                          input logic [31:0] p, input logic [31:0] e);
        drive(in_inst, a, b, im, src, p);
        push(nm, e);
        @(negedge clk);
        chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
        chk({nm, "_pc_jump"}, pc_jump, p + im);
        chk({nm, "_wr_data"}, wr_data, b);
        @(posedge clk);
        #1;
    endtask

    task automatic mop(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input int hold_cycles);
        int  n;
        bit  seen_done;
        n         = 0;
        seen_done = 0;
        drive(I_MOP | {17'd0, f3, 12'd0}, a, b, 32'd0, 1'b0, 32'h0000_0400);
        push(nm, e);
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk);
            if (stall) n++;
            else seen_done = 1;
        end
        chk({nm, "_stall_cycles"}, n, 33);
        if (hold_cycles > 0) hold = 1'b1;
        for (int k = 0; k < hold_cycles; k++) begin
            push({nm, "_held"}, e);
            @(posedge clk);
            #1;
            if (k == hold_cycles - 1) hold = 1'b0;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_stall"}, {31'd0, stall}, 32'd0);
        chk({nm, "_idle_state"}, {30'd0, dut.md_state}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // main sequence
    initial begin
        rst = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        valid = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_state", {30'd0, dut.md_state}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        alu_op("addi",  I_ADDI,  32'd5,        32'h0000_ABCD, 32'hFFFF_FFF9, 1'b1, 32'h100, 32'hFFFF_FFFE);
        alu_op("sub",   I_SUB,   32'd9,        32'd9,         32'd0,         1'b0, 32'h104, 32'd0);
        alu_op("sra",   I_SRA,   32'h8000_0000, 32'd4,        32'd0,         1'b0, 32'h108, 32'hF800_0000);
        alu_op("sll",   I_SLL,   32'd1,        32'h21,        32'd0,         1'b0, 32'h10C, 32'd2);
        alu_op("slt",   I_SLT,   32'd1,        32'hFFFF_FFFF, 32'd0,         1'b0, 32'h110, 32'd0);
        alu_op("sltu",  I_SLTU,  32'd1,        32'hFFFF_FFFF, 32'd0,         1'b0, 32'h114, 32'd1);
        alu_op("lui",   I_LUI,   32'h55,       32'd0,         32'h1234_5000, 1'b1, 32'h118, 32'h1234_5000);
        alu_op("auipc", I_AUIPC, 32'h55,       32'd0,         32'h2000,      1'b1, 32'h1000, 32'h3000);
        alu_op("blt",   I_BLT,   32'hFFFF_FFFF, 32'd1,        32'h40,        1'b1, 32'h120, 32'd1);
        alu_op("lw",    I_LW,    32'h100,      32'd3,         32'd8,         1'b0, 32'h124, 32'h108);

        mop("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        mop("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        mop("mulh",   3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0);
        mop("divu0",  3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 0);
        mop("rem0",   3'd6, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 0);
        mop("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        mop("rem_neg",3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        mop("div_neg",3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        mop("remu",   3'd7, 32'd100,       32'd7,         32'd2,         0);

        // flush at N+10 of a DIV
        drive(I_MOP | 32'h0000_4000, 32'd1000, 32'd7, 32'd0, 1'b0, 32'h200);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("flush_after_stall", {31'd0, stall}, 32'd0);
        chk("flush_after_state", {30'd0, dut.md_state}, 32'd0);
        @(posedge clk);
        #1;
        alu_op("add_after_flush", I_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 32'h204, 32'd42);

        // reset mid-BUSY
        drive(I_MOP, 32'd11, 32'd13, 32'd0, 1'b0, 32'h300);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_rst", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_state", {30'd0, dut.md_state}, 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        alu_op("add_after_rst", I_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 32'h304, 32'd3);

        // hold in DONE for 3 cycles
        mop("mul_hold", 3'd0, 32'd3, 32'd4, 32'd12, 3);

        repeat (3) @(posedge clk);
        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
